dmem_bus_if: RTL and testbench

Memory-stage data-memory bus interface for the pipelined core: accepts a load/store from the MEM stage (address, lane-aligned write data, byte-access pattern), runs it on a variable-latency valid/ack data-memory bus and stalls the pipeline until it completes. It sits downstream of the byte-access-pattern generator and upstream of the load-data extension mux, which consumes its raw read word.

---
 rtl/dmem_bus_if_pkg.sv | 21 ++
 rtl/dmem_wdog.sv | 30 +++
 rtl/dmem_bus_if.sv | 133 +++++++++++++
 tb/tb_dmem_bus_if.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_if_pkg.sv
// dmem_bus_if shared types: FSM state encoding,
// default bus timeout and byte-enable helper.
package dmem_bus_if_pkg;

  typedef enum logic [1:0] {
    DMEMIF_IDLE = 2'd0,
    DMEMIF_BUSY = 2'd1,
    DMEMIF_DONE = 2'd2
  } dmemif_state_e;

  localparam int DMEM_TIMEOUT = 255;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [3:0] bus_be(
    input logic       we,
    input logic [3:0] amp
  );
    return we ? amp : BE_WORD;
  endfunction

endpackage

// File: rtl/dmem_wdog.sv
// dmem_wdog: BUSY-cycle watchdog counter; expired flags
// the cycle in which the LIMIT-th un-acked cycle ends.
module dmem_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  // count un-acked BUSY cycles, restart on each new transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: MEM-stage valid/ack data-memory bus master.
// Optional bus timeout enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_if
  import dmem_bus_if_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = DMEM_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [3:0]           req_amp,
  output logic                 stall,
  output logic [XLEN-1:0]      rdata,
  output logic                 rdata_valid,
  output logic                 bus_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_rdata
);

  dmemif_state_e r_state;
  dmemif_state_e w_next;

  logic                 r_req;
  logic                 r_we;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [XLEN-1:0]      r_wdata;
  logic [3:0]           r_be;
  logic [XLEN-1:0]      r_rdata;

  logic w_accept;
  logic w_ack;
  logic w_tmo;
  logic w_unused_lsb;

  assign w_accept = (r_state == DMEMIF_IDLE) && req_valid;
  assign w_ack    = (r_state == DMEMIF_BUSY) && mem_ack;
  assign w_unused_lsb = ^req_addr[1:0];

`ifdef DMEM_TIMEOUT_EN
  logic r_bus_err;

  dmem_wdog #(
    .LIMIT(TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_accept),
    .i_en     ((r_state == DMEMIF_BUSY) && !mem_ack),
    .o_expired(w_tmo)
  );

  // one-cycle error pulse coincides with the DONE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_tmo;
    end
  end

  assign bus_err = r_bus_err;
`else
  logic w_unused_cfg;

  assign w_tmo        = 1'b0;
  assign bus_err      = 1'b0;
  assign w_unused_cfg = (TIMEOUT != 0);
`endif

  // next-state: accept in IDLE, wait for ack/timeout, one DONE cycle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      DMEMIF_IDLE: if (req_valid) w_next = DMEMIF_BUSY;
      DMEMIF_BUSY: if (w_ack || w_tmo) w_next = DMEMIF_DONE;
      DMEMIF_DONE: w_next = DMEMIF_IDLE;
      default:     w_next = DMEMIF_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DMEMIF_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // bus outputs held from accept until ack; read word captured on ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_req   <= 1'b1;
      r_we    <= req_we;
      r_addr  <= {req_addr[ADDR_SIZE-1:2], 2'b00};
      r_wdata <= req_wdata;
      r_be    <= bus_be(req_we, req_amp);
    end else if (w_ack) begin
      r_req <= 1'b0;
      if (!r_we) r_rdata <= mem_rdata;
    end else if (w_tmo) begin
      r_req   <= 1'b0;
      r_rdata <= '0;
    end
  end

  assign stall       = req_valid && (r_state != DMEMIF_DONE);
  assign rdata_valid = (r_state == DMEMIF_DONE) && !r_we && req_valid;
  assign rdata       = r_rdata;
  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_be      = r_be;

endmodule

// File: tb/tb_dmem_bus_if.sv
// tb_dmem_bus_if: directed stimulus, transaction-level
// reference model and per-cycle output comparison.
module tb_dmem_bus_if;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_amp;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dmem_bus_if #(
    .XLEN     (32),
    .ADDR_SIZE(32),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_amp    (req_amp),
    .stall      (stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: one outstanding transaction, then a completion cycle
  bit          m_out, m_done, m_err, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  int          m_wait;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_out = 0; m_done = 0; m_err = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0;
      m_wait = 0;
    end else if (m_done) begin
      m_done = 0;
      m_err  = 0;
    end else if (m_out) begin
      if (mem_ack) begin
        m_out  = 0;
        m_done = 1;
        if (!m_we) m_rdata = mem_rdata;
      end
`ifdef DMEM_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TO) begin
          m_out = 0; m_done = 1; m_err = 1; m_rdata = 0;
        end
      end
`endif
    end else if (req_valid) begin
      m_out   = 1;
      m_we    = req_we;
      m_addr  = req_addr & ~32'h3;
      m_wdata = req_wdata;
      m_be    = req_we ? req_amp : 4'hF;
      m_wait  = 0;
    end
  end

  // monitors feeding the hand-computed checks
  bit          en_cmp = 0;
  int          cyc = 0;
  bit          prev_req = 0;
  int          rises[$];
  int          falls[$];
  int          stall_cnt, busy_cnt, rdv_cnt, err_cnt;
  bit          wd_chg;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("stall", 32'(stall), 32'(req_valid && !m_done));
      chk("rdata_valid", 32'(rdata_valid),
          32'(m_done && !m_we && req_valid));
      chk("mem_req", 32'(mem_req), 32'(m_out));
      chk("rdata", rdata, m_rdata);
      chk("bus_err", 32'(bus_err), 32'(m_err));
      if (m_out) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_be", 32'(mem_be), 32'(m_be));
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      cyc++;
      if (stall) stall_cnt++;
      if (mem_req) busy_cnt++;
      if (rdata_valid) rdv_cnt++;
      if (bus_err) err_cnt++;
      if (mem_req && !prev_req) begin
        rises.push_back(cyc);
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_be    = mem_be;
      end
      if (!mem_req && prev_req) falls.push_back(cyc);
      if (mem_req && prev_req && mem_wdata !== cap_wdata) wd_chg = 1;
      prev_req = mem_req;
    end
  end

  task automatic clr_mon();
    stall_cnt = 0; busy_cnt = 0; rdv_cnt = 0; err_cnt = 0;
    wd_chg = 0;
    rises.delete();
    falls.delete();
  endtask

  // drive one op from cycle 0; returns just after the edge into DONE
  task automatic run_op(input logic we,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] amp,
                        input int lat,
                        input logic [31:0] rd,
                        input int flush_at);
    req_valid = 1; req_we = we; req_addr = a;
    req_wdata = wd; req_amp = amp;
    step();
    for (int k = 1; k <= lat; k++) begin
      if (k == flush_at) req_valid = 0;
      if (k == lat) begin
        mem_ack = 1;
        mem_rdata = rd;
      end
      step();
    end
    mem_ack = 0;
    mem_rdata = 32'h5A5A_5A5A;
  endtask

  initial begin
    reset = 1; req_valid = 0; req_we = 0; req_addr = 0;
    req_wdata = 0; req_amp = 0; mem_ack = 0; mem_rdata = 0;
    clr_mon();
    #2 reset = 0;
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rdv", 32'(rdata_valid), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    en_cmp = 1;
    step();
    reset = 1;
    step();

    // load, minimum latency
    clr_mon();
    run_op(0, 32'h104, 0, 4'b0100, 1, 32'hA1B2_C3D4, 0);
    @(negedge clk);
    chk("ld_rdv", 32'(rdata_valid), 1);
    chk("ld_rdata", rdata, 32'hA1B2_C3D4);
    chk("ld_stall_done", 32'(stall), 0);
    chk("ld_stall_cycles", stall_cnt, 2);
    chk("ld_addr", cap_addr, 32'h104);
    chk("ld_be", 32'(cap_be), 32'hF);
    step();
    req_valid = 0;
    step();

    // store, ack in 5th bus cycle
    clr_mon();
    run_op(1, 32'h206, 32'hBEEF_0000, 4'b1100, 5, 32'h1111_2222, 0);
    @(negedge clk);
    chk("st_rdv", 32'(rdata_valid), 0);
    chk("st_rdata_hold", rdata, 32'hA1B2_C3D4);
    chk("st_addr", cap_addr, 32'h204);
    chk("st_be", 32'(cap_be), 32'hC);
    chk("st_wdata", cap_wdata, 32'hBEEF_0000);
    chk("st_wdata_stable", 32'(wd_chg), 0);
    chk("st_bus_cycles", busy_cnt, 5);
    chk("st_stall_cycles", stall_cnt, 6);
    step();
    req_valid = 0;
    step();
    chk("st_rdv_never", rdv_cnt, 0);

    // back-to-back loads
    clr_mon();
    run_op(0, 32'h300, 0, 4'b1111, 1, 32'h0102_0304, 0);
    @(negedge clk);
    chk("b2b_rdata0", rdata, 32'h0102_0304);
    step();
    run_op(0, 32'h308, 0, 4'b0011, 1, 32'hCAFE_F00D, 0);
    @(negedge clk);
    chk("b2b_rdata1", rdata, 32'hCAFE_F00D);
    chk("b2b_addr1", cap_addr, 32'h308);
    step();
    req_valid = 0;
    step();
    chk("b2b_txns", rises.size(), 2);
    chk("b2b_rdv", rdv_cnt, 2);
    if (rises.size() == 2 && falls.size() >= 1) begin
      chk("b2b_spacing", rises[1] - rises[0], 3);
      chk("b2b_gap", rises[1] - falls[0], 2);
    end

    // flush during BUSY
    clr_mon();
    run_op(0, 32'h400, 0, 4'b0001, 3, 32'h7777_8888, 1);
    @(negedge clk);
    chk("fl_rdv", 32'(rdata_valid), 0);
    chk("fl_stall", 32'(stall), 0);
    chk("fl_bus_cycles", busy_cnt, 3);
    step();
    step();
    chk("fl_idle_req", 32'(mem_req), 0);
    chk("fl_rdv_never", rdv_cnt, 0);

`ifdef DMEM_TIMEOUT_EN
    // no ack: timeout after TO bus cycles
    clr_mon();
    run_op(0, 32'h600, 0, 4'b1111, 0, 0, 0);
    for (int k = 1; k <= TO; k++) step();
    @(negedge clk);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_rdata", rdata, 0);
    chk("to_rdv", 32'(rdata_valid), 1);
    chk("to_stall", 32'(stall), 0);
    chk("to_bus_cycles", busy_cnt, 8);
    step();
    req_valid = 0;
    step();
    chk("to_err_pulses", err_cnt, 1);

    // ack on the limit cycle wins
    clr_mon();
    run_op(0, 32'h700, 0, 4'b1111, TO, 32'h0BAD_F00D, 0);
    @(negedge clk);
    chk("to8_bus_err", 32'(bus_err), 0);
    chk("to8_rdata", rdata, 32'h0BAD_F00D);
    step();
    req_valid = 0;
    step();
    chk("to8_err_pulses", err_cnt, 0);
`endif

    // reset during BUSY, late ack afterwards
    clr_mon();
    req_valid = 1; req_we = 0; req_addr = 32'h500; req_amp = 4'hF;
    step();
    step();
    #2;
    reset = 0;
    req_valid = 0;
    #1;
    chk("rb_mem_req", 32'(mem_req), 0);
    chk("rb_rdata", rdata, 0);
    chk("rb_stall", 32'(stall), 0);
    step();
    reset = 1;
    mem_ack = 1;
    mem_rdata = 32'h9999_9999;
    step();
    mem_ack = 0;
    @(negedge clk);
    chk("rb_late_req", 32'(mem_req), 0);
    chk("rb_late_rdata", rdata, 0);
    step();
    step();
    chk("rb_rdv", rdv_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
